// File: rtl/copy_master_pkg.sv
// Shared types and default widths for the on-chip memory copy master.
// Holds the FSM state enum, the bus command enum and width defaults.
package copy_master_pkg;

    localparam int ADDR_W_DEF     = 13;
    localparam int DATA_W_DEF     = 32;
    localparam int LEN_W_DEF      = 14;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        RD,
        WR
    } cmd_t;

endpackage

// File: rtl/copy_master_fifo.sv
// Show-ahead synchronous FIFO buffering read data ahead of the writes.
// Ports: clk/reset_n, clear, push/wdata, pop/rdata, count, empty, full.
module copy_master_fifo
    import copy_master_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            count <= count + CW'(do_push)
                           - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/onchip_memory_copy_master.sv
// Avalon-MM master copying a block of words from src to dst addresses.
// Ports: start/abort/src/dst/length in, busy/done/aborted out, avm_* bus.
module onchip_memory_copy_master
    import copy_master_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_n;
    cmd_t              cmd;
    cmd_t              cmd_n;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  rd_left;
    logic [LEN_W-1:0]  wr_left;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     out_n;
    logic [CW:0]       lvl;
    logic              abort_r;
    logic              aborted_r;

    logic              rd_acc;
    logic              wr_acc;
    logic              free;
    logic              rdv;
    logic              abort_act;
    logic              data_avail;
    logic              load_start;
    logic              load_rd;
    logic              load_wr;
    logic              fin_norm;
    logic              fin_abort;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clear;
    logic [DATA_W-1:0] fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    assign rd_acc    = (cmd == RD) && !avm_waitrequest;
    assign wr_acc    = (cmd == WR) && !avm_waitrequest;
    assign free      = (cmd == NONE) || !avm_waitrequest;
    assign rdv       = avm_readdatavalid && (state == RUN);
    assign abort_act = abort || abort_r;

    // A word returning this cycle can feed a write straight away.
    assign data_avail = !fifo_empty || rdv;

    // Reads pending plus buffered must stay below the FIFO depth.
    assign lvl = {1'b0, outstanding}
               + {1'b0, fifo_count}
               + (CW+1)'(rd_acc);
    assign out_n = outstanding + CW'(rd_acc) - CW'(rdv);

    // Bypass: an empty FIFO hands the returning word to the write.
    assign fifo_push  = rdv && !(load_wr && fifo_empty);
    assign fifo_pop   = load_wr && !fifo_empty;
    assign fifo_clear = (state == FINISH);

    always_comb begin
        state_n    = state;
        cmd_n      = cmd;
        load_start = 1'b0;
        load_rd    = 1'b0;
        load_wr    = 1'b0;
        fin_norm   = 1'b0;
        fin_abort  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_n = FINISH;
                    end else begin
                        state_n    = RUN;
                        cmd_n      = RD;
                        load_start = 1'b1;
                    end
                end
            end
            RUN: begin
                fin_norm  = wr_acc && (wr_left == '0);
                fin_abort = abort_act && free
                         && (out_n == '0);
                if (free) begin
                    cmd_n = NONE;
                    if (!abort_act && data_avail
                        && wr_left != '0) begin
                        cmd_n   = WR;
                        load_wr = 1'b1;
                    end else if (!abort_act
                        && rd_left != '0
                        && !fifo_full
                        && lvl < (CW+1)'(FIFO_DEPTH)) begin
                        cmd_n   = RD;
                        load_rd = 1'b1;
                    end
                end
                if (fin_norm || fin_abort)
                    state_n = FINISH;
            end
            FINISH: begin
                state_n = IDLE;
                cmd_n   = NONE;
            end
            default: begin
                state_n = IDLE;
                cmd_n   = NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cmd   <= NONE;
        end else begin
            state <= state_n;
            cmd   <= cmd_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr       <= '0;
            wr_addr       <= '0;
            rd_left       <= '0;
            wr_left       <= '0;
            outstanding   <= '0;
            abort_r       <= 1'b0;
            aborted_r     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            outstanding <= out_n;
            if (load_start) begin
                avm_address <= src_addr;
                rd_addr     <= src_addr + ADDR_W'(1);
                wr_addr     <= dst_addr;
                rd_left     <= length - LEN_W'(1);
                wr_left     <= length;
            end
            if (load_rd) begin
                avm_address <= rd_addr;
                rd_addr     <= rd_addr + ADDR_W'(1);
                rd_left     <= rd_left - LEN_W'(1);
            end
            if (load_wr) begin
                avm_address   <= wr_addr;
                wr_addr       <= wr_addr + ADDR_W'(1);
                wr_left       <= wr_left - LEN_W'(1);
                avm_writedata <= fifo_empty ? avm_readdata
                                            : fifo_rdata;
            end
            if (state == RUN && abort)
                abort_r <= 1'b1;
            else if (state == FINISH)
                abort_r <= 1'b0;
            if (state == IDLE && start)
                aborted_r <= 1'b0;
            else if (fin_norm || fin_abort)
                aborted_r <= !fin_norm;
        end
    end

    copy_master_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (fifo_clear),
        .push    (fifo_push),
        .wdata   (avm_readdata),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign busy           = (state == RUN);
    assign done           = (state == FINISH);
    assign aborted        = done && aborted_r;
    assign avm_read       = (cmd == RD);
    assign avm_write      = (cmd == WR);
    assign avm_byteenable = avm_write ? '1 : '0;

endmodule

// File: tb/tb_onchip_memory_copy_master.sv
// Self-checking bench for onchip_memory_copy_master.
// Slave model with variable latency/stalls; table plus directed sequences.
module tb_onchip_memory_copy_master;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int LW = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;

    onchip_memory_copy_master dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .abort             (abort),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [12:0] a);
        return {16'hDA7A, 3'b000, a};
    endfunction

    int lat  = 1;
    int wpct = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int stab_err = 0;
    int both_err = 0;
    int be_err = 0;
    logic [AW-1:0] rd_log [256];
    logic [AW-1:0] wr_log [256];
    logic [DW-1:0] wd_log [256];
    logic          pv [8];
    logic [DW-1:0] pd [8];
    logic          p_hold;
    logic          p_rd;
    logic          p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;

    initial begin : slave
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        p_hold = 1'b0;
        p_rd   = 1'b0;
        p_wr   = 1'b0;
        p_addr = '0;
        p_data = '0;
        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            avm_readdatavalid = pv[0];
            avm_readdata      = pd[0];
            for (int i = 0; i < 7; i++) begin
                pv[i] = pv[i+1];
                pd[i] = pd[i+1];
            end
            pv[7] = 1'b0;
            avm_waitrequest =
                (int'($urandom_range(99)) < wpct);
            @(negedge clk);
            if (!reset_n) begin
                p_hold = 1'b0;
            end else begin
                if (avm_read && avm_write)
                    both_err++;
                if (p_hold && (avm_read !== p_rd
                    || avm_write !== p_wr
                    || avm_address !== p_addr
                    || (p_wr && avm_writedata !== p_data)))
                    stab_err++;
                p_hold = (avm_read || avm_write)
                      && avm_waitrequest;
                p_rd   = avm_read;
                p_wr   = avm_write;
                p_addr = avm_address;
                p_data = avm_writedata;
                if (avm_read && !avm_waitrequest) begin
                    rd_log[rd_cnt % 256] = avm_address;
                    rd_cnt++;
                    pv[lat-1] = 1'b1;
                    pd[lat-1] = pat(avm_address);
                end
                if (avm_write && !avm_waitrequest) begin
                    wr_log[wr_cnt % 256] = avm_address;
                    wd_log[wr_cnt % 256] = avm_writedata;
                    wr_cnt++;
                    if (avm_byteenable !== 4'hF)
                        be_err++;
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;
    int mx = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic go(input logic [AW-1:0] s,
                      input logic [AW-1:0] d,
                      input logic [LW-1:0] n);
        @(posedge clk);
        #1;
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget,
                             output int cyc,
                             output logic ab);
        cyc = 0;
        ab  = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (rd_cnt - wr_cnt > mx)
                mx = rd_cnt - wr_cnt;
            if (done) begin
                cyc = c;
                ab  = aborted;
                break;
            end
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " aborted"}, 32'(aborted), 0);
        chk({tag, " read"}, 32'(avm_read), 0);
        chk({tag, " write"}, 32'(avm_write), 0);
        chk({tag, " addr"}, 32'(avm_address), 0);
        chk({tag, " wdata"}, avm_writedata, 0);
        chk({tag, " be"}, 32'(avm_byteenable), 0);
    endtask

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        int            lat;
        int            wpct;
        int            exp_cyc;
        int            exp_mx;
    } vec_t;

    vec_t vt [4];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int cyc;
        int r0;
        int w0;
        logic ab;
        logic [AW-1:0] ea;

        vt[0] = '{13'h0000, 13'h0200, 14'd8,  1, 40, 0, 0};
        vt[1] = '{13'h0040, 13'h0900, 14'd20, 5, 0,  0, 4};
        vt[2] = '{13'h1FFE, 13'h0800, 14'd4,  1, 0,  9, 0};
        vt[3] = '{13'h0A00, 13'h1FFE, 14'd5,  2, 30, 0, 0};

        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        lat  = 1;
        wpct = 0;
        go(13'h010, 13'h100, 14'd1);
        @(negedge clk);
        chk("len1 T1 read", 32'(avm_read), 1);
        chk("len1 T1 addr", 32'(avm_address), 32'h010);
        chk("len1 T1 busy", 32'(busy), 1);
        chk("len1 T1 write", 32'(avm_write), 0);
        @(negedge clk);
        chk("len1 T2 cmd", 32'({avm_read, avm_write}), 0);
        @(negedge clk);
        chk("len1 T3 write", 32'(avm_write), 1);
        chk("len1 T3 addr", 32'(avm_address), 32'h100);
        chk("len1 T3 data", avm_writedata, pat(13'h010));
        chk("len1 T3 be", 32'(avm_byteenable), 32'hF);
        @(negedge clk);
        chk("len1 T4 done", 32'(done), 1);
        chk("len1 T4 aborted", 32'(aborted), 0);
        chk("len1 T4 busy", 32'(busy), 0);
        @(negedge clk);
        chk("len1 T5 done", 32'(done), 0);

        for (int i = 0; i < 4; i++) begin
            lat  = vt[i].lat;
            wpct = vt[i].wpct;
            r0   = rd_cnt;
            w0   = wr_cnt;
            mx   = 0;
            go(vt[i].src, vt[i].dst, vt[i].len);
            wait_done(2000, cyc, ab);
            chk($sformatf("v%0d done seen", i),
                32'(cyc != 0), 1);
            chk($sformatf("v%0d aborted", i), 32'(ab), 0);
            if (vt[i].exp_cyc != 0)
                chk($sformatf("v%0d done cycle", i),
                    32'(cyc), 32'(vt[i].exp_cyc));
            if (vt[i].exp_mx != 0)
                chk($sformatf("v%0d max in flight", i),
                    32'(mx), 32'(vt[i].exp_mx));
            @(negedge clk);
            chk($sformatf("v%0d done pulse", i),
                32'(done), 0);
            chk($sformatf("v%0d reads", i),
                32'(rd_cnt - r0), 32'(vt[i].len));
            chk($sformatf("v%0d writes", i),
                32'(wr_cnt - w0), 32'(vt[i].len));
            for (int k = 0; k < int'(vt[i].len); k++) begin
                ea = vt[i].src + AW'(k);
                chk($sformatf("v%0d rd addr %0d", i, k),
                    32'(rd_log[(r0 + k) % 256]), 32'(ea));
                chk($sformatf("v%0d wr data %0d", i, k),
                    wd_log[(w0 + k) % 256], pat(ea));
                ea = vt[i].dst + AW'(k);
                chk($sformatf("v%0d wr addr %0d", i, k),
                    32'(wr_log[(w0 + k) % 256]), 32'(ea));
            end
        end

        lat  = 1;
        wpct = 0;
        r0   = rd_cnt;
        w0   = wr_cnt;
        go(13'h123, 13'h456, 14'd0);
        @(negedge clk);
        chk("len0 T1 done", 32'(done), 1);
        chk("len0 T1 busy", 32'(busy), 0);
        chk("len0 T1 cmd", 32'({avm_read, avm_write}), 0);
        chk("len0 T1 aborted", 32'(aborted), 0);
        @(negedge clk);
        chk("len0 T2 done", 32'(done), 0);
        repeat (3) @(negedge clk);
        chk("len0 traffic",
            32'((rd_cnt - r0) + (wr_cnt - w0)), 0);

        lat = 2;
        r0  = rd_cnt;
        w0  = wr_cnt;
        go(13'h300, 13'h400, 14'd10);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        wait_done(50, cyc, ab);
        chk("abort done cycle", 32'(cyc), 3);
        chk("abort aborted", 32'(ab), 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort reads", 32'(rd_cnt - r0), 3);
        chk("abort writes", 32'(wr_cnt - w0), 1);
        chk("abort wr addr", 32'(wr_log[w0 % 256]), 32'h400);
        chk("abort wr data", wd_log[w0 % 256], pat(13'h300));
        chk("abort busy", 32'(busy), 0);

        lat = 1;
        r0  = rd_cnt;
        w0  = wr_cnt;
        go(13'h500, 13'h600, 14'd4);
        src_addr = 13'h700;
        dst_addr = 13'h780;
        length   = 14'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, cyc, ab);
        chk("busy start done seen", 32'(cyc != 0), 1);
        repeat (10) @(negedge clk);
        chk("busy start reads", 32'(rd_cnt - r0), 4);
        chk("busy start writes", 32'(wr_cnt - w0), 4);
        chk("busy start rd3", 32'(rd_log[(r0 + 3) % 256]),
            32'h503);
        chk("busy start wr3", 32'(wr_log[(w0 + 3) % 256]),
            32'h603);

        go(13'h010, 13'h020, 14'd8);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        r0 = rd_cnt;
        wait_done(20, cyc, ab);
        chk("midreset no done", 32'(cyc), 0);
        chk("midreset no reads", 32'(rd_cnt - r0), 0);
        chk("midreset busy", 32'(busy), 0);

        chk("stall stability", 32'(stab_err), 0);
        chk("read and write", 32'(both_err), 0);
        chk("byteenable", 32'(be_err), 0);

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
